hash_selftest_seq: RTL and testbench

HASH_SELFTEST_SEQ -- requirements
Module: hash_selftest_seq

---
 rtl/hash_selftest_seq.sv | 220 ++++++++++++++++++++++
 tb/tb_hash_selftest_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_selftest_seq.sv
// Hash core self-test: streams a ROM message into the core, captures the digest,
// then compares it byte by byte against the expected digest stored in ROM.
module hash_selftest_seq #(
  parameter int MSG_BYTES  = 3,
  parameter int HASH_BYTES = 32,
  parameter int TIMEOUT    = 4096
) (
  input  logic       clk,
  input  logic       rst_async,
  input  logic       start_i,
  output logic [6:0] rom_addr_o,
  input  logic [7:0] rom_data_i,
  output logic [7:0] data_o,
  output logic [2:0] data_ctrl_o,
  input  logic       ready_i,
  input  logic       hash_v_i,
  input  logic [7:0] hash_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       pass_o,
  output logic       timeout_o,
  output logic       proto_err_o,
  output logic [6:0] mismatch_cnt_o
);

  localparam int HW = (HASH_BYTES > 1) ? $clog2(HASH_BYTES) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [6:0]    LAST_MSG  = 7'(MSG_BYTES - 1);
  localparam logic [6:0]    LAST_HASH = 7'(HASH_BYTES - 1);
  localparam logic [6:0]    CMP_END   = 7'(HASH_BYTES);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, SEND, WAIT_HASH, CAPTURE, COMPARE, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [6:0]    idx_q, idx_d;
  logic [7:0]    data_q, data_d;
  logic          load_q, load_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          pass_q, pass_d;
  logic          timeout_q, timeout_d;
  logic          proto_err_q, proto_err_d;
  logic [6:0]    mismatch_q, mismatch_d;

  logic [7:0]    hash_mem_q [HASH_BYTES];
  logic          mem_we;
  logic [HW-1:0] mem_waddr;
  logic [HW-1:0] cmp_rd;
  logic [7:0]    send_byte;
  logic [1:0]    cmd;
  logic          mismatch_hit;

  // ROM data arrives in the first SEND cycle only; after that the latched copy is held
  assign send_byte = load_q ? rom_data_i : data_q;
  assign cmp_rd    = idx_q[HW-1:0] - HW'(1);
  assign mismatch_hit = (rom_data_i != hash_mem_q[cmp_rd]);

  always_comb begin
    cmd = 2'b10;
    if (idx_q == LAST_MSG) begin
      cmd = 2'b11;
    end else if (idx_q == 7'd0) begin
      cmd = 2'b01;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    data_d      = data_q;
    load_d      = 1'b0;
    wait_cnt_d  = wait_cnt_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    proto_err_d = proto_err_q;
    mismatch_d  = mismatch_q;
    mem_we      = 1'b0;
    mem_waddr   = idx_q[HW-1:0];
    rom_addr_o  = 7'd0;
    data_ctrl_o = 3'b000;

    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d     = FETCH;
          idx_d       = 7'd0;
          pass_d      = 1'b0;
          timeout_d   = 1'b0;
          proto_err_d = 1'b0;
          mismatch_d  = 7'd0;
        end
      end

      FETCH: begin
        rom_addr_o = idx_q;
        if (hash_v_i) begin
          proto_err_d = 1'b1;
          pass_d      = 1'b0;
          state_d     = DONE;
        end else begin
          load_d  = 1'b1;
          state_d = SEND;
        end
      end

      SEND: begin
        data_ctrl_o = {1'b1, cmd};
        data_d      = send_byte;
        if (hash_v_i) begin
          proto_err_d = 1'b1;
          pass_d      = 1'b0;
          state_d     = DONE;
        end else if (ready_i) begin
          if (idx_q == LAST_MSG) begin
            wait_cnt_d = '0;
            state_d    = WAIT_HASH;
          end else begin
            idx_d   = idx_q + 7'd1;
            state_d = FETCH;
          end
        end
      end

      WAIT_HASH: begin
        if (hash_v_i) begin
          mem_we    = 1'b1;
          mem_waddr = '0;
          if (HASH_BYTES == 1) begin
            idx_d   = 7'd0;
            state_d = COMPARE;
          end else begin
            idx_d   = 7'd1;
            state_d = CAPTURE;
          end
        end else if (wait_cnt_q == TO_LAST) begin
          timeout_d = 1'b1;
          pass_d    = 1'b0;
          state_d   = DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end

      CAPTURE: begin
        if (hash_v_i) begin
          mem_we = 1'b1;
          if (idx_q == LAST_HASH) begin
            idx_d   = 7'd0;
            state_d = COMPARE;
          end else begin
            idx_d = idx_q + 7'd1;
          end
        end else begin
          proto_err_d = 1'b1;
          pass_d      = 1'b0;
          state_d     = DONE;
        end
      end

      COMPARE: begin
        // idx_q issues address k while the byte fetched last cycle (k-1) is checked
        if (idx_q != CMP_END) begin
          rom_addr_o = 7'd64 + idx_q;
        end
        if (idx_q != 7'd0 && mismatch_hit && mismatch_q != 7'd127) begin
          mismatch_d = mismatch_q + 7'd1;
        end
        if (idx_q == CMP_END) begin
          pass_d  = (mismatch_d == 7'd0);
          state_d = DONE;
        end else begin
          idx_d = idx_q + 7'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      state_q     <= IDLE;
      idx_q       <= 7'd0;
      data_q      <= 8'd0;
      load_q      <= 1'b0;
      wait_cnt_q  <= '0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      proto_err_q <= 1'b0;
      mismatch_q  <= 7'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      load_q      <= load_d;
      wait_cnt_q  <= wait_cnt_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      proto_err_q <= proto_err_d;
      mismatch_q  <= mismatch_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      hash_mem_q[mem_waddr] <= hash_i;
    end
  end

  assign data_o         = send_byte;
  assign busy_o         = (state_q != IDLE) && (state_q != DONE);
  assign done_o         = (state_q == DONE);
  assign pass_o         = pass_q;
  assign timeout_o      = timeout_q;
  assign proto_err_o    = proto_err_q;
  assign mismatch_cnt_o = mismatch_q;

endmodule

// File: tb/tb_hash_selftest_seq.sv
// Bench for hash_selftest_seq: ROM and hash-core models, per-cycle message checker,
// directed runs for pass, stall, corruption, timeout, protocol error and reset abort.
module tb_hash_selftest_seq;
  localparam int MSG = 3;
  localparam int HB  = 32;
  localparam int TO  = 16;

  logic       clk = 1'b0;
  logic       rst_async;
  logic       start_i;
  logic [6:0] rom_addr_o;
  logic [7:0] rom_data_i;
  logic [7:0] data_o;
  logic [2:0] data_ctrl_o;
  logic       ready_i;
  logic       hash_v_i;
  logic [7:0] hash_i;
  logic       busy_o, done_o, pass_o, timeout_o, proto_err_o;
  logic [6:0] mismatch_cnt_o;

  hash_selftest_seq #(.MSG_BYTES(MSG), .HASH_BYTES(HB), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_async(rst_async), .start_i(start_i),
    .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
    .data_o(data_o), .data_ctrl_o(data_ctrl_o), .ready_i(ready_i),
    .hash_v_i(hash_v_i), .hash_i(hash_i),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .timeout_o(timeout_o),
    .proto_err_o(proto_err_o), .mismatch_cnt_o(mismatch_cnt_o)
  );

  always #5 clk = ~clk;

  logic [7:0]   rom [128];
  logic [7:0]   dig [HB];
  logic [255:0] gold;
  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int acc_base = 0;
  int stalls   = 0;
  int stall_base = 0;

  // synchronous ROM: data one cycle after the address
  always @(posedge clk) rom_data_i <= rom[rom_addr_o];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_cmd(input int k);
    if (k == MSG - 1) return 2'b11;
    if (k == 0) return 2'b01;
    return 2'b10;
  endfunction

  function automatic int model_mismatch();
    int m = 0;
    for (int i = 0; i < HB; i++) if (dig[i] != rom[64 + i]) m++;
    return m;
  endfunction

  // message stream checker: every valid cycle must present the next expected byte
  always @(negedge clk) begin
    if (!rst_async) begin
      check("busy_done_excl", {31'd0, busy_o & done_o}, 32'd0);
      if (data_ctrl_o[2]) begin
        int k;
        k = n_acc - acc_base;
        check("valid_needs_busy", {31'd0, busy_o}, 32'd1);
        if (k < MSG) begin
          check("msg_data", {24'd0, data_o}, {24'd0, rom[k]});
          check("msg_cmd", {30'd0, data_ctrl_o[1:0]}, {30'd0, exp_cmd(k)});
        end else begin
          check("extra_byte", k, MSG - 1);
        end
        if (ready_i) n_acc++;
        else stalls++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_acc(input int n, input string nm);
    for (int i = 0; i < 200; i++) begin
      if (n_acc - acc_base >= n) return;
      tick();
    end
    check(nm, n_acc - acc_base, n);
  endtask

  task automatic send_digest(input int nbytes);
    repeat (2) tick();
    for (int i = 0; i < nbytes; i++) begin
      hash_v_i = 1'b1;
      hash_i   = dig[i];
      tick();
    end
    hash_v_i = 1'b0;
    hash_i   = 8'd0;
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 300; i++) begin
      if (done_o) return;
      tick();
    end
    check(nm, {31'd0, done_o}, 32'd1);
  endtask

  task automatic check_result(input string tag, input logic ep, input int emm,
                              input logic eto, input logic epe);
    check({tag, "_done"}, {31'd0, done_o}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
    check({tag, "_pass"}, {31'd0, pass_o}, {31'd0, ep});
    check({tag, "_mismatch"}, {25'd0, mismatch_cnt_o}, emm);
    check({tag, "_timeout"}, {31'd0, timeout_o}, {31'd0, eto});
    check({tag, "_proto"}, {31'd0, proto_err_o}, {31'd0, epe});
  endtask

  initial begin
    int k;
    rst_async = 1'b1;
    start_i   = 1'b0;
    ready_i   = 1'b1;
    hash_v_i  = 1'b0;
    hash_i    = 8'd0;
    gold = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    for (int i = 0; i < 128; i++) rom[i] = 8'd0;
    rom[0] = 8'h61; rom[1] = 8'h62; rom[2] = 8'h63;
    for (int i = 0; i < HB; i++) rom[64 + i] = gold[255 - 8*i -: 8];

    repeat (3) tick();
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    rst_async = 1'b0;
    check("rst_ctrl", {29'd0, data_ctrl_o}, 32'd0);
    check("rst_pass", {31'd0, pass_o}, 32'd0);
    check("rst_timeout", {31'd0, timeout_o}, 32'd0);
    check("rst_proto", {31'd0, proto_err_o}, 32'd0);
    check("rst_mismatch", {25'd0, mismatch_cnt_o}, 32'd0);
    tick();

    // clean "abc" run with the correct digest
    for (int i = 0; i < HB; i++) dig[i] = rom[64 + i];
    acc_base = n_acc;
    do_start();
    check("start_busy", {31'd0, busy_o}, 32'd1);
    wait_acc(MSG, "t1_acc_wait");
    send_digest(HB);
    wait_done("t1_done_wait");
    check_result("t1", 1'b1, 0, 1'b0, 1'b0);
    check("t1_model_mm", {25'd0, mismatch_cnt_o}, model_mismatch());
    check("t1_byte0_lit", {24'd0, dig[0]}, 32'hba);
    repeat (5) tick();
    check("t1_done_hold", {31'd0, done_o}, 32'd1);
    check("t1_pass_hold", {31'd0, pass_o}, 32'd1);
    check("t1_acc_count", n_acc - acc_base, MSG);

    // ready low for 5 SEND cycles on byte 1
    acc_base = n_acc;
    stall_base = stalls;
    do_start();
    check("t2_done_clr", {31'd0, done_o}, 32'd0);
    check("t2_pass_clr", {31'd0, pass_o}, 32'd0);
    wait_acc(1, "t2_acc1_wait");
    ready_i = 1'b0;
    tick();
    repeat (5) tick();
    ready_i = 1'b1;
    wait_acc(MSG, "t2_acc_wait");
    send_digest(HB);
    wait_done("t2_done_wait");
    check_result("t2", 1'b1, 0, 1'b0, 1'b0);
    check("t2_stall_cycles", stalls - stall_base, 5);
    check("t2_acc_count", n_acc - acc_base, MSG);

    // digest bytes 0 and 31 corrupted
    dig[0]  = dig[0] ^ 8'hff;
    dig[31] = dig[31] ^ 8'hff;
    acc_base = n_acc;
    do_start();
    wait_acc(MSG, "t3_acc_wait");
    send_digest(HB);
    wait_done("t3_done_wait");
    check_result("t3", 1'b0, 2, 1'b0, 1'b0);
    check("t3_model_mm", {25'd0, mismatch_cnt_o}, model_mismatch());

    // no digest: timeout 16 cycles after the last accept
    acc_base = n_acc;
    do_start();
    wait_acc(MSG, "t4_acc_wait");
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (timeout_o) begin
        k = i;
        break;
      end
    end
    check("t4_timeout_latency", k, TO);
    check_result("t4", 1'b0, 0, 1'b1, 1'b0);

    // digest stops after 10 bytes
    for (int i = 0; i < HB; i++) dig[i] = rom[64 + i];
    acc_base = n_acc;
    do_start();
    check("t5_timeout_clr", {31'd0, timeout_o}, 32'd0);
    wait_acc(MSG, "t5_acc_wait");
    send_digest(10);
    wait_done("t5_done_wait");
    check_result("t5", 1'b0, 0, 1'b0, 1'b1);

    // reset while stalled in SEND, then a clean rerun with an ignored busy start
    acc_base = n_acc;
    do_start();
    wait_acc(1, "t6_acc1_wait");
    ready_i = 1'b0;
    repeat (2) tick();
    check("t6_in_send", {31'd0, data_ctrl_o[2]}, 32'd1);
    rst_async = 1'b1;
    #2;
    check("t6_rst_busy", {31'd0, busy_o}, 32'd0);
    check("t6_rst_proto", {31'd0, proto_err_o}, 32'd0);
    tick();
    rst_async = 1'b0;
    ready_i = 1'b1;
    check("t6_valid_after_rst", {31'd0, data_ctrl_o[2]}, 32'd0);
    tick();
    check("t6_idle_valid", {31'd0, data_ctrl_o[2]}, 32'd0);
    check("t6_idle_done", {31'd0, done_o}, 32'd0);
    acc_base = n_acc;
    do_start();
    wait_acc(1, "t6_rerun_acc1");
    do_start();
    wait_acc(MSG, "t6_acc_wait");
    send_digest(HB);
    wait_done("t6_done_wait");
    check_result("t6", 1'b1, 0, 1'b0, 1'b0);
    check("t6_acc_count", n_acc - acc_base, MSG);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
